// File: rtl/cache_ctrl_fsm_p.sv
// Direct-mapped cache controller FSM: hit service, dirty write-back, line refill
// and whole-cache flush, with per-line valid/dirty bits held internally.
module cache_ctrl_fsm_p #(
  parameter int WORDS_PER_LINE = 16,
  parameter int NUM_LINES      = 8,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int IDX_W         = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             wr_rd,
  input  logic [IDX_W-1:0] index,
  input  logic             hit,
  input  logic             mem_ack,
  input  logic             flush_req,
  output logic             rdy,
  output logic [IDX_W-1:0] line_idx,
  output logic [OFF_W-1:0] addr_offset,
  output logic             memstrb,
  output logic             wr_rd_sdram,
  output logic             mux_sel,
  output logic             demux_sel,
  output logic             wen_sram,
  output logic             tag_we,
  output logic             valid_out,
  output logic             dirty_out,
  output logic             flush_done
);

  typedef enum logic [2:0] {
    IDLE, WRITE_HIT, READ_HIT, MISS, WRITEBACK, REFILL, FLUSH_SCAN
  } state_t;

  state_t               state_reg, state_next;
  logic                 req_wr_reg, req_wr_next;
  logic [IDX_W-1:0]     req_idx_reg, req_idx_next;
  logic [OFF_W-1:0]     offset_reg, offset_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic                 flush_path_reg, flush_path_next;
  logic                 memstrb_reg, memstrb_next;
  logic [NUM_LINES-1:0] valid_reg, valid_next;
  logic [NUM_LINES-1:0] dirty_reg, dirty_next;

  logic [IDX_W-1:0]     cur_line;
  logic                 complete;
  logic                 last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_wr_reg     <= 1'b0;
      req_idx_reg    <= '0;
      offset_reg     <= '0;
      ptr_reg        <= '0;
      flush_path_reg <= 1'b0;
      memstrb_reg    <= 1'b0;
      valid_reg      <= '0;
      dirty_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      req_wr_reg     <= req_wr_next;
      req_idx_reg    <= req_idx_next;
      offset_reg     <= offset_next;
      ptr_reg        <= ptr_next;
      flush_path_reg <= flush_path_next;
      memstrb_reg    <= memstrb_next;
      valid_reg      <= valid_next;
      dirty_reg      <= dirty_next;
    end
  end

  // The flush path addresses lines through the scan pointer, requests through req_idx.
  assign cur_line  = flush_path_reg ? ptr_reg : req_idx_reg;
  assign complete  = memstrb_reg & mem_ack;
  assign last_word = (offset_reg == OFF_W'(WORDS_PER_LINE - 1));

  assign line_idx    = cur_line;
  assign addr_offset = offset_reg;
  assign memstrb     = memstrb_reg;
  assign valid_out   = valid_reg[cur_line];
  assign dirty_out   = dirty_reg[cur_line];

  always_comb begin
    state_next      = state_reg;
    req_wr_next     = req_wr_reg;
    req_idx_next    = req_idx_reg;
    offset_next     = offset_reg;
    ptr_next        = ptr_reg;
    flush_path_next = flush_path_reg;
    memstrb_next    = 1'b0;
    valid_next      = valid_reg;
    dirty_next      = dirty_reg;
    rdy             = 1'b0;
    wr_rd_sdram     = 1'b0;
    mux_sel         = 1'b0;
    demux_sel       = 1'b0;
    wen_sram        = 1'b0;
    tag_we          = 1'b0;
    flush_done      = 1'b0;

    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (cs) begin
          req_wr_next  = wr_rd;
          req_idx_next = index;
          if (hit && valid_reg[index]) state_next = wr_rd ? WRITE_HIT : READ_HIT;
          else                         state_next = MISS;
        end else if (flush_req) begin
          ptr_next        = '0;
          flush_path_next = 1'b1;
          state_next      = FLUSH_SCAN;
        end
      end
      WRITE_HIT: begin
        wen_sram                = 1'b1;
        dirty_next[req_idx_reg] = 1'b1;
        state_next              = IDLE;
      end
      READ_HIT: begin
        demux_sel  = 1'b1;
        state_next = IDLE;
      end
      MISS: begin
        offset_next = '0;
        if (valid_reg[req_idx_reg] && dirty_reg[req_idx_reg]) state_next = WRITEBACK;
        else                                                  state_next = REFILL;
      end
      WRITEBACK: begin
        wr_rd_sdram  = 1'b1;
        memstrb_next = ~complete;
        if (complete) begin
          offset_next = offset_reg + 1'b1;
          if (last_word) begin
            dirty_next[cur_line] = 1'b0;
            state_next           = flush_path_reg ? FLUSH_SCAN : REFILL;
          end
        end
      end
      REFILL: begin
        mux_sel      = 1'b1;
        wen_sram     = complete;
        memstrb_next = ~complete;
        if (complete) begin
          offset_next = offset_reg + 1'b1;
          if (last_word) begin
            tag_we                  = 1'b1;
            valid_next[req_idx_reg] = 1'b1;
            dirty_next[req_idx_reg] = 1'b0;
            state_next              = req_wr_reg ? WRITE_HIT : READ_HIT;
          end
        end
      end
      FLUSH_SCAN: begin
        if (valid_reg[ptr_reg] && dirty_reg[ptr_reg]) begin
          offset_next = '0;
          state_next  = WRITEBACK;
        end else if (ptr_reg == IDX_W'(NUM_LINES - 1)) begin
          flush_done      = 1'b1;
          flush_path_next = 1'b0;
          ptr_next        = '0;
          state_next      = IDLE;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
